// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/flush controller.
package hazard_stall_ctrl_pkg;

    // Tuse encoding: cycles until the D-stage instruction consumes an operand.
    localparam logic [1:0] TUSE_NEVER = 2'd3;

    // Tnew encoding: cycles until a producer's result can be forwarded.
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    // Busy cycles of the mult/div unit after the starting instruction leaves E.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Width of the register specifier fields.
    localparam int REG_W = 5;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // True when a D-stage source matches a not-yet-ready producer.
    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_hazard(
        input logic [REG_W-1:0] src,
        input logic [1:0]       tuse,
        input logic [REG_W-1:0] wa,
        input logic [1:0]       tnew
    );
        return (src != '0) && (src == wa) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_timer.sv
// Mult/div occupancy timer: IDLE/BUSY FSM with a down counter loaded on start.
module mdu_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Load the latency on a start from IDLE, count down to the last busy cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        state <= MDU_BUSY;
                        cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                MDU_BUSY: begin
                    // A start while busy is ignored; the guard on <=1 keeps cnt from wrapping.
                    if (cnt <= CNT_W'(1)) begin
                        state <= MDU_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= MDU_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == MDU_BUSY);

`ifndef SYNTHESIS
    // A new mult/div cannot reach E while D is held behind a busy unit.
    start_while_busy_a: assert property (@(posedge clk) disable iff (!reset)
        !(start && state == MDU_BUSY))
        else $error("mdu_busy_timer: start asserted while busy");
`endif

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: register-hazard and mult/div-hazard detection for the
// D stage, driving the PC and IF/ID enables and the ID/EX bubble.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic [1:0]       D_rs_tuse,
    input  logic [1:0]       D_rt_tuse,
    input  logic             D_is_mdu,
    input  logic [REG_W-1:0] E_wa,
    input  logic [1:0]       E_tnew,
    input  logic [REG_W-1:0] M_wa,
    input  logic [1:0]       M_tnew,
    input  logic             E_mdu_start,
    input  logic             E_mdu_is_div,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_flush,
    output logic             mdu_busy,
    output logic             stall
);

    logic reg_stall;
    logic mdu_stall;

    mdu_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (E_mdu_start),
        .is_div (E_mdu_is_div),
        .busy   (mdu_busy)
    );

    // Combine hazards; while reset is held the pipeline free-runs with no bubbles.
    always_comb begin
        reg_stall = reg_hazard(D_rs, D_rs_tuse, E_wa, E_tnew)
                  | reg_hazard(D_rs, D_rs_tuse, M_wa, M_tnew)
                  | reg_hazard(D_rt, D_rt_tuse, E_wa, E_tnew)
                  | reg_hazard(D_rt, D_rt_tuse, M_wa, M_tnew);
        mdu_stall = D_is_mdu & (mdu_busy | E_mdu_start);
        stall     = reset & (reg_stall | mdu_stall);
        pc_en     = ~stall;
        fd_en     = ~stall;
        de_flush  = stall;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       D_is_mdu, E_mdu_start, E_mdu_is_div;
    logic       pc_en, fd_en, de_flush, mdu_busy, stall;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs         (D_rs),
        .D_rt         (D_rt),
        .D_rs_tuse    (D_rs_tuse),
        .D_rt_tuse    (D_rt_tuse),
        .D_is_mdu     (D_is_mdu),
        .E_wa         (E_wa),
        .E_tnew       (E_tnew),
        .M_wa         (M_wa),
        .M_tnew       (M_tnew),
        .E_mdu_start  (E_mdu_start),
        .E_mdu_is_div (E_mdu_is_div),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .de_flush     (de_flush),
        .mdu_busy     (mdu_busy),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks all control outputs for a given expected stall and busy.
    task automatic chk_out(input string tag, input logic exp_stall, input logic exp_busy);
        chk({tag, ".stall"},    32'(stall),    32'(exp_stall));
        chk({tag, ".pc_en"},    32'(pc_en),    32'(!exp_stall));
        chk({tag, ".fd_en"},    32'(fd_en),    32'(!exp_stall));
        chk({tag, ".de_flush"}, 32'(de_flush), 32'(exp_stall));
        chk({tag, ".busy"},     32'(mdu_busy), 32'(exp_busy));
    endtask

    task automatic clear_inputs();
        D_rs = '0; D_rt = '0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_is_mdu = 1'b0;
        E_wa = '0; E_tnew = '0; M_wa = '0; M_tnew = '0;
        E_mdu_start = 1'b0; E_mdu_is_div = 1'b0;
    endtask

    // Move to the next cycle: inputs change just after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        // 1: reset held low forces a free-running pipeline despite hazards
        reset = 1'b0;
        clear_inputs();
        E_mdu_start = 1'b1; D_rs = 5'd5; E_wa = 5'd5; D_rs_tuse = 2'd0; E_tnew = 2'd2;
        D_is_mdu = 1'b1;
        #1 chk_out("rst0", 1'b0, 1'b0);
        next_cycle(); #1 chk_out("rst1", 1'b0, 1'b0);
        next_cycle(); #1 chk_out("rst2", 1'b0, 1'b0);
        clear_inputs();
        reset = 1'b1;
        #1 chk_out("idle", 1'b0, 1'b0);

        // 2: load-use on rs, then resolved once the load reaches M with tnew 1
        next_cycle();
        E_wa = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_rs_tuse = 2'd1;
        #1 chk_out("lw_e", 1'b1, 1'b0);
        next_cycle();
        E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd8; M_tnew = 2'd1;
        #1 chk_out("lw_m", 1'b0, 1'b0);
        // rt needed now (tuse 0) from M producer with tnew 1 -> stall
        D_rs = 5'd0; D_rt = 5'd8; D_rt_tuse = 2'd0;
        #1 chk_out("rt_m", 1'b1, 1'b0);
        // rt matches E with tuse equal to tnew -> no stall
        M_wa = 5'd0; M_tnew = 2'd0; E_wa = 5'd8; E_tnew = 2'd1; D_rt_tuse = 2'd1;
        #1 chk_out("rt_eq", 1'b0, 1'b0);
        // operand never used
        E_tnew = 2'd2; D_rt_tuse = 2'd3;
        #1 chk_out("never", 1'b0, 1'b0);

        // 3: register 0 never stalls
        next_cycle();
        clear_inputs();
        D_rt = 5'd0; E_wa = 5'd0; E_tnew = 2'd2; D_rt_tuse = 2'd0;
        D_rs = 5'd0; D_rs_tuse = 2'd0; M_wa = 5'd0; M_tnew = 2'd2;
        #1 chk_out("r0", 1'b0, 1'b0);

        // 4: mult start at t, busy t+1..t+5, D_is_mdu stalls t..t+5
        next_cycle();
        clear_inputs();
        D_is_mdu = 1'b1; E_mdu_start = 1'b1; E_mdu_is_div = 1'b0;
        #1 chk_out("mult_t", 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            E_mdu_start = 1'b0;
            #1 chk_out($sformatf("mult_t%0d", k), 1'b1, 1'b1);
        end
        next_cycle(); #1 chk_out("mult_t6", 1'b0, 1'b0);

        // start with a non-MDU instruction in D: busy but no stall
        next_cycle();
        D_is_mdu = 1'b0; E_mdu_start = 1'b1;
        #1 chk_out("mult_nd", 1'b0, 1'b0);
        next_cycle(); E_mdu_start = 1'b0;
        #1 chk_out("mult_nd1", 1'b0, 1'b1);
        for (int k = 2; k <= 6; k++) next_cycle();
        #1 chk_out("mult_nd6", 1'b0, 1'b0);

        // 5: div start, reset pulse in busy cycle 4 clears immediately
        next_cycle();
        D_is_mdu = 1'b0; E_mdu_start = 1'b1; E_mdu_is_div = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            E_mdu_start = 1'b0; E_mdu_is_div = 1'b0;
            #1 chk("div_busy", 32'(mdu_busy), 32'd1);
        end
        #1 reset = 1'b0;
        #1 chk_out("div_rst", 1'b0, 1'b0);
        #1 reset = 1'b1;
        D_is_mdu = 1'b1;
        #1 chk_out("div_rel", 1'b0, 1'b0);
        next_cycle(); #1 chk_out("div_rel1", 1'b0, 1'b0);
        // a div runs the full 10 busy cycles
        E_mdu_start = 1'b1; E_mdu_is_div = 1'b1;
        #1 chk_out("div_t", 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            E_mdu_start = 1'b0;
            #1 chk(($sformatf("div_t%0d", k)), 32'(mdu_busy), 32'd1);
        end
        next_cycle(); #1 chk_out("div_t11", 1'b0, 1'b0);

        // 6: reg and mdu hazards together give one bubble per cycle
        next_cycle();
        clear_inputs();
        D_is_mdu = 1'b1; E_mdu_start = 1'b1;
        E_wa = 5'd9; E_tnew = 2'd2; D_rs = 5'd9; D_rs_tuse = 2'd0;
        #1 chk_out("both_t", 1'b1, 1'b0);
        next_cycle();
        E_mdu_start = 1'b0;
        #1 chk_out("both_t1", 1'b1, 1'b1);
        E_wa = 5'd0; E_tnew = 2'd0;
        #1 chk_out("mdu_only", 1'b1, 1'b1);
        for (int k = 2; k <= 6; k++) next_cycle();
        #1 chk_out("both_end", 1'b0, 1'b0);
        D_is_mdu = 1'b0; M_wa = 5'd9; M_tnew = 2'd1;
        #1 chk_out("reg_only", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
